fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Round-robin write arbiter that shares one `sync_fifo` write port among `NREQ` producers. Each producer offers beats on a valid/ready handshake and marks packet ends with `last`. The arbiter holds the grant for a whole packet, so packets never interleave inside the FIFO. It drives the FIFO's `wr_en`/`wdata` and uses `fifo_full` for backpressure. A `MAXBURST` guard stops one producer from holding the port forever.

## Interface
- `NREQ`, 4: number of requesters (2..16).
- `WIDTH`, 32: data width; must match the FIFO `WIDTH`.
- `MAXBURST`, 16: maximum beats per grant before forced release (≥1).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input NREQ: per-requester beat valid.
- `req_last` input NREQ: per-requester end-of-packet marker, qualified by valid.
- `req_data` input NREQ*WIDTH: requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_ready` output NREQ: per-requester beat accepted this cycle.
- `fifo_full` input 1: full flag from the FIFO.
- `wr_en` output 1: FIFO write strobe.
- `wdata` output WIDTH: FIFO write data.
- `grant_id` output clog2(NREQ): current or last granted requester.
- `busy` output 1: arbiter is locked to a packet.
- `burst_err` output 1: sticky flag, set on any forced release.

## Operation
- State machine with two states: IDLE and LOCK. Registered state holds: `state`, `grant_id`, `last_id`, `beat_cnt` (clog2(MAXBURST+1) bits), `burst_err`.
- **Candidate:**
  - In IDLE, the candidate is the first asserted `req_valid` scanning `last_id+1, last_id+2, …` modulo NREQ. This is combinational.
  - In LOCK, the candidate is `grant_id`.
- **Transfer:**
  - `req_ready[c] = cand_valid & ~fifo_full`. All other `req_ready` bits are 0.
  - `wr_en = req_valid[c] & req_ready[c]`.
  - `wdata = req_data[c]`. `wdata` is don't-care when `wr_en`=0.
- **IDLE transitions** (apply only on a transfer):
  - If `req_last[c]`: stay in IDLE and set `last_id <= c`.
  - Otherwise: go to LOCK, set `grant_id <= c` and `beat_cnt <= 1`.
  - No transfer: no state change.
  - `fifo_full` in IDLE causes no grant and no pointer movement.
- **LOCK transitions** (apply only on a transfer):
  - On a transfer, increment `beat_cnt`.
  - If `req_last[grant_id]`: go to IDLE and set `last_id <= grant_id`.
  - Else if `beat_cnt+1 == MAXBURST`: go to IDLE, set `last_id <= grant_id`, set `burst_err <= 1`.
- In LOCK, a deasserted `req_valid[grant_id]` holds the lock. There is no timeout on idle gaps.
- `busy = (state == LOCK)`.
- `grant_id` updates to c on every IDLE transfer, including single-beat packets.
- `burst_err` is cleared only by `rst`.
- `rst` asserted mid-packet aborts the lock with no FIFO side effect beyond beats already written.

## Timing
- Reset values:
  - state IDLE, `last_id` = NREQ-1 (requester 0 has first priority), `grant_id` 0, `beat_cnt` 0, `busy` 0, `burst_err` 0.
  - While `rst`=1, force `req_ready` = 0 and `wr_en` = 0.
- Zero-cycle arbitration: a beat presented in IDLE with FIFO not full is written in the same cycle.
- Back-to-back packets from different requesters need no bubble cycle.
- `fifo_full` is sampled combinationally. With the FIFO's registered full flag this is exact: no write is ever issued while `fifo_full`=1.
- Maximum 1 beat per cycle. Sustained throughput is 1 beat per cycle while the FIFO is not full.
- A requester must hold `valid`/`data`/`last` stable until `ready`. The arbiter does not check this.
- `last_id` updates only at packet end or forced release. Mid-packet beats do not rotate priority.

## Test plan
- **Reset priority:** after reset, assert `req_valid` = 4'b1111 with all `req_last`=1. Required: grants in order 0,1,2,3,0; `wr_en` high every cycle; FIFO contents match the per-requester data tags.
- **Packet lock:** req1 sends a 3-beat packet (last on beat 3) while req2 holds valid. Required: `busy`=1 for beats 2–3; `req_ready[2]`=0 until req1's last beat; req2's first beat is written the cycle after req1's last beat.
- **Full backpressure:** fill the FIFO to full (16 entries for ADDR=4) while req0 is mid-packet. Required: `wr_en`=0 and `req_ready`=0 while full; the lock is held. One FIFO read lets the next req0 beat through the following cycle.
- **MAXBURST:** MAXBURST=4, req3 sends 6 beats with no last, and req0 is valid. Required: forced release after beat 4; `burst_err`=1; req0 is granted next.
- **Valid gap:** req2 drops valid for 3 cycles mid-packet. Required: `busy` stays 1; no other requester is granted.
- **Reset mid-packet:** reset in LOCK after 2 beats. Required: all outputs return to their reset values immediately; after release, priority restarts at requester 0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter sharing one FIFO write port among NREQ producers.
// A grant is held for a whole packet; MAXBURST forces a release.
module fifo_wr_arb #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 32,
   parameter int MAXBURST = 16,
   localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int CW      = $clog2(MAXBURST + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_last,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  fifo_full,
   output logic                  wr_en,
   output logic [WIDTH-1:0]      wdata,
   output logic [IDW-1:0]        grant_id,
   output logic                  busy,
   output logic                  burst_err
);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   grantId_q, grantId_d;
   logic [IDW-1:0]   lastId_q, lastId_d;
   logic [CW-1:0]    beatCnt_q, beatCnt_d;
   logic             burstErr_q, burstErr_d;

   logic [IDW-1:0]   candId;
   logic             candValid;
   logic             xfer;
   logic [IDW:0]     scanIdx;
   logic [CW-1:0]    beatNext;
   logic [WIDTH-1:0] reqDataArr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : gSplit
      assign reqDataArr[g] = req_data[g*WIDTH +: WIDTH];
   end

   // Scan from the farthest offset down so the requester nearest last_id+1 wins.
   always_comb begin
      candValid = 1'b0;
      candId    = grantId_q;
      scanIdx   = '0;
      if (state_q == LOCK) begin
         candValid = req_valid[grantId_q];
      end else begin
         for (int k = NREQ; k >= 1; k--) begin
            scanIdx = {1'b0, lastId_q} + (IDW+1)'(k);
            if (scanIdx >= (IDW+1)'(NREQ)) begin
               scanIdx = scanIdx - (IDW+1)'(NREQ);
            end
            if (req_valid[scanIdx[IDW-1:0]]) begin
               candValid = 1'b1;
               candId    = scanIdx[IDW-1:0];
            end
         end
      end
   end

   always_comb begin
      req_ready         = '0;
      xfer              = candValid & ~fifo_full & ~rst;
      req_ready[candId] = xfer;
      wr_en             = xfer;
      wdata             = reqDataArr[candId];
   end

   assign beatNext = beatCnt_q + CW'(1);

   always_comb begin
      state_d    = state_q;
      grantId_d  = grantId_q;
      lastId_d   = lastId_q;
      beatCnt_d  = beatCnt_q;
      burstErr_d = burstErr_q;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               grantId_d = candId;
               beatCnt_d = CW'(1);
               if (req_last[candId]) begin
                  lastId_d = candId;
               end else if (MAXBURST == 1) begin
                  // A one-beat budget is exhausted by the first beat itself.
                  lastId_d   = candId;
                  burstErr_d = 1'b1;
               end else begin
                  state_d = LOCK;
               end
            end
         end
         LOCK: begin
            if (xfer) begin
               beatCnt_d = beatNext;
               if (req_last[grantId_q]) begin
                  state_d  = IDLE;
                  lastId_d = grantId_q;
               end else if (beatNext == CW'(MAXBURST)) begin
                  state_d    = IDLE;
                  lastId_d   = grantId_q;
                  burstErr_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grantId_q  <= '0;
         lastId_q   <= IDW'(NREQ - 1);
         beatCnt_q  <= '0;
         burstErr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grantId_q  <= grantId_d;
         lastId_q   <= lastId_d;
         beatCnt_q  <= beatCnt_d;
         burstErr_q <= burstErr_d;
      end
   end

   assign grant_id  = grantId_q;
   assign busy      = (state_q == LOCK);
   assign burst_err = burstErr_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed self-checking bench for fifo_wr_arb with a 16-entry FIFO occupancy model.
module tb_fifo_wr_arb;

   localparam int NREQ     = 4;
   localparam int WIDTH    = 32;
   localparam int MAXBURST = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       reqValid = '0;
   logic [NREQ-1:0]       reqLast = '0;
   logic [NREQ*WIDTH-1:0] reqData = '0;
   logic [NREQ-1:0]       reqReady;
   logic                  fifoFull;
   logic                  wrEn;
   logic [WIDTH-1:0]      wdata;
   logic [1:0]            grantId;
   logic                  busy;
   logic                  burstErr;

   int   fifoCnt = 0;
   int   fifoLoadVal = 0;
   logic fifoLoad = 1'b0;
   logic rdReq = 1'b0;
   int   testCnt = 0;
   int   failCnt = 0;

   fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXBURST(MAXBURST)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (reqValid),
      .req_last  (reqLast),
      .req_data  (reqData),
      .req_ready (reqReady),
      .fifo_full (fifoFull),
      .wr_en     (wrEn),
      .wdata     (wdata),
      .grant_id  (grantId),
      .busy      (busy),
      .burst_err (burstErr)
   );

   always #5 clk = ~clk;

   // Registered full flag, as the real FIFO provides.
   assign fifoFull = (fifoCnt >= 16);
   always @(posedge clk) begin
      if (fifoLoad) fifoCnt <= fifoLoadVal;
      else          fifoCnt <= fifoCnt + (wrEn ? 1 : 0) - (rdReq ? 1 : 0);
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: observed timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l);
      reqValid = v;
      reqLast  = l;
   endtask

   task automatic setData(input int i, input logic [31:0] val);
      reqData[i*WIDTH +: WIDTH] = val;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkXfer(input string tag, input logic [3:0] readyExp, input logic [31:0] dataExp);
      checkOutput({tag, " ready"}, 32'(reqReady), 32'(readyExp));
      checkOutput({tag, " wr_en"}, 32'(wrEn), 32'(readyExp != 4'b0000));
      if (readyExp != 4'b0000) checkOutput({tag, " wdata"}, wdata, dataExp);
   endtask

   initial begin
      // Reset state, with every requester already offering a beat.
      applyStimulus(4'b1111, 4'b1111);
      for (int i = 0; i < NREQ; i++) setData(i, 32'hA000_0000 + 32'(i));
      #2;
      checkXfer("rst", 4'b0000, 32'h0);
      checkOutput("rst busy", 32'(busy), 32'h0);
      checkOutput("rst gid", 32'(grantId), 32'h0);
      checkOutput("rst berr", 32'(burstErr), 32'h0);
      tick;
      rst = 1'b0;

      // Reset priority: single-beat packets rotate 0,1,2,3,0.
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         checkXfer($sformatf("prio%0d", n), 4'(1 << (n % 4)), 32'hA000_0000 + 32'(n % 4));
         checkOutput($sformatf("prio%0d busy", n), 32'(busy), 32'h0);
         tick;
         checkOutput($sformatf("prio%0d gid", n), 32'(grantId), 32'(n % 4));
      end

      // Packet lock: req1 three beats while req2 waits.
      applyStimulus(4'b0110, 4'b0100);
      setData(1, 32'hB000_0001);
      setData(2, 32'hC000_0000);
      @(negedge clk);
      checkXfer("lock b1", 4'b0010, 32'hB000_0001);
      checkOutput("lock b1 busy", 32'(busy), 32'h0);
      tick;
      setData(1, 32'hB000_0002);
      @(negedge clk);
      checkXfer("lock b2", 4'b0010, 32'hB000_0002);
      checkOutput("lock b2 busy", 32'(busy), 32'h1);
      tick;
      applyStimulus(4'b0110, 4'b0110);
      setData(1, 32'hB000_0003);
      @(negedge clk);
      checkXfer("lock b3", 4'b0010, 32'hB000_0003);
      checkOutput("lock b3 busy", 32'(busy), 32'h1);
      tick;
      applyStimulus(4'b0100, 4'b0100);
      @(negedge clk);
      checkXfer("lock req2", 4'b0100, 32'hC000_0000);
      checkOutput("lock req2 busy", 32'(busy), 32'h0);
      tick;
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("lock gid", 32'(grantId), 32'h2);

      // Full backpressure: FIFO fills while req0 is mid-packet.
      fifoLoad    = 1'b1;
      fifoLoadVal = 14;
      tick;
      fifoLoad = 1'b0;
      applyStimulus(4'b0001, 4'b0000);
      setData(0, 32'hD000_0000);
      @(negedge clk);
      checkXfer("full b1", 4'b0001, 32'hD000_0000);
      tick;
      setData(0, 32'hD000_0001);
      @(negedge clk);
      checkXfer("full b2", 4'b0001, 32'hD000_0001);
      tick;
      applyStimulus(4'b0011, 4'b0011);
      setData(0, 32'hD000_0002);
      setData(1, 32'hE000_0000);
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         checkXfer($sformatf("full hold%0d", n), 4'b0000, 32'h0);
         checkOutput($sformatf("full hold%0d busy", n), 32'(busy), 32'h1);
         if (n == 1) rdReq = 1'b1;
         tick;
      end
      rdReq = 1'b0;
      @(negedge clk);
      checkXfer("full b3", 4'b0001, 32'hD000_0002);
      tick;
      @(negedge clk);
      checkXfer("full idle", 4'b0000, 32'h0);
      checkOutput("full idle busy", 32'(busy), 32'h0);
      applyStimulus(4'b0000, 4'b0000);
      fifoLoad    = 1'b1;
      fifoLoadVal = 0;
      tick;
      fifoLoad = 1'b0;

      // MAXBURST: req3 streams without last; forced release after beat 4.
      applyStimulus(4'b1001, 4'b0001);
      setData(0, 32'h0000_000A);
      for (int n = 1; n <= 4; n++) begin
         setData(3, 32'hF000_0000 + 32'(n));
         @(negedge clk);
         checkXfer($sformatf("mb b%0d", n), 4'b1000, 32'hF000_0000 + 32'(n));
         checkOutput($sformatf("mb b%0d berr", n), 32'(burstErr), 32'h0);
         tick;
      end
      @(negedge clk);
      checkOutput("mb berr", 32'(burstErr), 32'h1);
      checkOutput("mb busy", 32'(busy), 32'h0);
      checkXfer("mb req0", 4'b0001, 32'h0000_000A);
      tick;
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("mb gid", 32'(grantId), 32'h0);
      checkOutput("mb berr sticky", 32'(burstErr), 32'h1);

      // Valid gap: req2 drops valid mid-packet while others request.
      applyStimulus(4'b0100, 4'b0000);
      setData(2, 32'hC000_0001);
      @(negedge clk);
      checkXfer("gap b1", 4'b0100, 32'hC000_0001);
      tick;
      setData(2, 32'hC000_0002);
      @(negedge clk);
      checkXfer("gap b2", 4'b0100, 32'hC000_0002);
      tick;
      applyStimulus(4'b0011, 4'b0011);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         checkXfer($sformatf("gap idle%0d", n), 4'b0000, 32'h0);
         checkOutput($sformatf("gap idle%0d busy", n), 32'(busy), 32'h1);
         tick;
      end
      applyStimulus(4'b0111, 4'b0111);
      setData(2, 32'hC000_0003);
      @(negedge clk);
      checkXfer("gap b3", 4'b0100, 32'hC000_0003);
      tick;
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("gap busy", 32'(busy), 32'h0);
      checkOutput("gap gid", 32'(grantId), 32'h2);

      // Reset mid-packet: req1 locked after two beats.
      applyStimulus(4'b0010, 4'b0000);
      setData(1, 32'hB100_0001);
      @(negedge clk);
      checkXfer("rmp b1", 4'b0010, 32'hB100_0001);
      tick;
      setData(1, 32'hB100_0002);
      @(negedge clk);
      checkXfer("rmp b2", 4'b0010, 32'hB100_0002);
      tick;
      checkOutput("rmp locked", 32'(busy), 32'h1);
      applyStimulus(4'b1111, 4'b1111);
      for (int i = 0; i < NREQ; i++) setData(i, 32'hA000_0000 + 32'(i));
      rst = 1'b1;
      #1;
      checkXfer("rmp rst", 4'b0000, 32'h0);
      checkOutput("rmp rst busy", 32'(busy), 32'h0);
      checkOutput("rmp rst gid", 32'(grantId), 32'h0);
      checkOutput("rmp rst berr", 32'(burstErr), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkXfer("rmp prio0", 4'b0001, 32'hA000_0000);
      tick;
      @(negedge clk);
      checkXfer("rmp prio1", 4'b0010, 32'hA000_0001);
      tick;
      applyStimulus(4'b0000, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
      $finish;
   end

endmodule
